// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew feeder for a 4x4 systolic array.
// Latches one A/B block pair, streams it into the west/north edges with
// row i / column j delayed by i / j cycles, waits DRAIN_CYCLES, then
// pulses res_valid.
// Optional build macro: SKEW_FEEDER_B_COLMAJOR_EN (b_blk packed column-major).
module systolic_skew_feeder #(
    parameter int unsigned BIT_WIDTH    = 16,
    parameter int unsigned FRAC_WIDTH   = 8,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [16*BIT_WIDTH-1:0]     a_blk,
    input  logic [16*BIT_WIDTH-1:0]     b_blk,
    output logic signed [BIT_WIDTH-1:0] west_in0,
    output logic signed [BIT_WIDTH-1:0] west_in1,
    output logic signed [BIT_WIDTH-1:0] west_in2,
    output logic signed [BIT_WIDTH-1:0] west_in3,
    output logic signed [BIT_WIDTH-1:0] north_in0,
    output logic signed [BIT_WIDTH-1:0] north_in1,
    output logic signed [BIT_WIDTH-1:0] north_in2,
    output logic signed [BIT_WIDTH-1:0] north_in3,
    output logic                        acc_clr,
    output logic                        busy,
    output logic                        res_valid
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // Fixed-point format is carried through untouched; only sanity-check it.
    if (FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must be smaller than BIT_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [2:0]              t_q;
    logic [DW-1:0]           d_q;
    logic [16*BIT_WIDTH-1:0] a_q;
    logic [16*BIT_WIDTH-1:0] b_q;
    logic [BIT_WIDTH-1:0]    west_q  [4];
    logic [BIT_WIDTH-1:0]    north_q [4];
    logic                    acc_clr_q;
    logic                    res_valid_q;

    // A[row][t-row] when the skewed index is inside the block, else 0.
    function automatic logic [BIT_WIDTH-1:0] west_word(input logic [16*BIT_WIDTH-1:0] blk,
                                                       input int row, input int t);
        int k;
        k = t - row;
        if (k < 0 || k > 3) return '0;
        return blk[(4*row+k)*BIT_WIDTH +: BIT_WIDTH];
    endfunction

    // B[t-col][col] when the skewed index is inside the block, else 0.
    function automatic logic [BIT_WIDTH-1:0] north_word(input logic [16*BIT_WIDTH-1:0] blk,
                                                        input int col, input int t);
        int k;
        k = t - col;
        if (k < 0 || k > 3) return '0;
`ifdef SKEW_FEEDER_B_COLMAJOR_EN
        return blk[(4*col+k)*BIT_WIDTH +: BIT_WIDTH];
`else
        return blk[(4*k+col)*BIT_WIDTH +: BIT_WIDTH];
`endif
    endfunction

    // Control FSM with registered data/strobe outputs computed for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            t_q         <= '0;
            d_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
        end else begin
            // Outputs are zero unless the next cycle is a feed cycle.
            acc_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q       <= a_blk;
                        b_q       <= b_blk;
                        t_q       <= '0;
                        state_q   <= StFeed;
                        acc_clr_q <= 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            west_q[i]  <= west_word(a_blk, i, 0);
                            north_q[i] <= north_word(b_blk, i, 0);
                        end
                    end
                end
                StFeed: begin
                    if (t_q == 3'd6) begin
                        t_q <= '0;
                        d_q <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state_q     <= StDone;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else begin
                        t_q <= t_q + 3'd1;
                        for (int i = 0; i < 4; i++) begin
                            west_q[i]  <= west_word(a_q, i, int'(t_q) + 1);
                            north_q[i] <= north_word(b_q, i, int'(t_q) + 1);
                        end
                    end
                end
                StDrain: begin
                    if (d_q == DW'(DRAIN_CYCLES - 1)) begin
                        d_q         <= '0;
                        state_q     <= StDone;
                        res_valid_q <= 1'b1;
                    end else begin
                        d_q <= d_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign acc_clr   = acc_clr_q;
    assign res_valid = res_valid_q;
    assign west_in0  = west_q[0];
    assign west_in1  = west_q[1];
    assign west_in2  = west_q[2];
    assign west_in3  = west_q[3];
    assign north_in0 = north_q[0];
    assign north_in1 = north_q[1];
    assign north_in2 = north_q[2];
    assign north_in3 = north_q[3];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: a cycle-level reference model
// pushes the expected output vector after every edge, a monitor pops and
// compares on the falling edge.
module tb_systolic_skew_feeder;

    localparam int BW = 16;
    localparam int D  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [16*BW-1:0] a_blk;
    logic [16*BW-1:0] b_blk;
    logic signed [BW-1:0] west_in0, west_in1, west_in2, west_in3;
    logic signed [BW-1:0] north_in0, north_in1, north_in2, north_in3;
    logic            acc_clr;
    logic            busy;
    logic            res_valid;

    systolic_skew_feeder #(
        .BIT_WIDTH   (BW),
        .FRAC_WIDTH  (8),
        .DRAIN_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_blk    (a_blk),
        .b_blk    (b_blk),
        .west_in0 (west_in0),
        .west_in1 (west_in1),
        .west_in2 (west_in2),
        .west_in3 (west_in3),
        .north_in0(north_in0),
        .north_in1(north_in1),
        .north_in2(north_in2),
        .north_in3(north_in3),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][BW-1:0] w;
        logic [3:0][BW-1:0] n;
        logic               acc;
        logic               rv;
        logic               rdy;
        logic               bsy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   model_rv  = 0;
    int   seen_rv   = 0;

    // Word position of B[k][j] inside b_blk for this build.
    function automatic int b_pos(input int k, input int j);
`ifdef SKEW_FEEDER_B_COLMAJOR_EN
        return 4*j + k;
`else
        return 4*k + j;
`endif
    endfunction

    function automatic logic [16*BW-1:0] rand_blk();
        logic [16*BW-1:0] v;
        for (int n = 0; n < 16; n++) v[n*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic v, input logic r, input logic [16*BW-1:0] a,
                        input logic [16*BW-1:0] b);
        in_valid = v;
        rst      = r;
        a_blk    = a;
        b_blk    = b;
        @(negedge clk);
    endtask

    // Reference model: transaction-level view of the feed schedule.
    initial begin : model
        int c;
        logic [BW-1:0] ma [4][4];
        logic [BW-1:0] mb [4][4];
        exp_t e;
        c = -1;
        forever begin
            @(posedge clk);
            if (rst) begin
                c = -1;
            end else if (c < 0) begin
                if (in_valid) begin
                    for (int r = 0; r < 4; r++) begin
                        for (int q = 0; q < 4; q++) begin
                            ma[r][q] = a_blk[(4*r+q)*BW +: BW];
                            mb[r][q] = b_blk[b_pos(r, q)*BW +: BW];
                        end
                    end
                    c = 0;
                end
            end else if (c == 7 + D) begin
                c = -1;
            end else begin
                c++;
            end
            e = '0;
            if (c < 0) begin
                e.rdy = 1'b1;
            end else begin
                e.bsy = 1'b1;
                e.acc = (c == 0);
                e.rv  = (c == 7 + D);
                for (int x = 0; x < 4; x++) begin
                    if (c - x >= 0 && c - x <= 3) begin
                        e.w[x] = ma[x][c-x];
                        e.n[x] = mb[c-x][x];
                    end
                end
                if (e.rv) model_rv++;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented output vector against the scoreboard.
    initial begin : monitor
        exp_t e;
        logic [3:0][BW-1:0] aw;
        logic [3:0][BW-1:0] an;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                aw = {west_in3, west_in2, west_in1, west_in0};
                an = {north_in3, north_in2, north_in1, north_in0};
                for (int x = 0; x < 4; x++) begin
                    check($sformatf("west_in%0d", x), 64'(aw[x]), 64'(e.w[x]));
                    check($sformatf("north_in%0d", x), 64'(an[x]), 64'(e.n[x]));
                end
                check("acc_clr", 64'(acc_clr), 64'(e.acc));
                check("res_valid", 64'(res_valid), 64'(e.rv));
                check("in_ready", 64'(in_ready), 64'(e.rdy));
                check("busy", 64'(busy), 64'(e.bsy));
                if (res_valid === 1'b1) seen_rv++;
            end
        end
    end

    initial begin : stimulus
        logic [16*BW-1:0] a1, b1, bn;
        a1 = '0;
        b1 = rand_blk();
        bn = '0;
        // A[i][k] = (k+1).0 ; B column 0 = 1.0, column 1 = 2.0.
        for (int r = 0; r < 4; r++) begin
            for (int q = 0; q < 4; q++) a1[(4*r+q)*BW +: BW] = BW'((q + 1) * 256);
            b1[b_pos(r, 0)*BW +: BW] = 16'h0100;
            b1[b_pos(r, 1)*BW +: BW] = 16'h0200;
        end
        for (int n = 0; n < 16; n++) bn[n*BW +: BW] = BW'(n * 256);

        // Reset with a block offered: nothing may be accepted.
        step(1'b1, 1'b1, rand_blk(), rand_blk());
        step(1'b1, 1'b1, rand_blk(), rand_blk());

        // Directed block, then valid held with A changing every cycle.
        step(1'b1, 1'b0, a1, b1);
        for (int s = 0; s < 14; s++) step(1'b1, 1'b0, rand_blk(), rand_blk());
        for (int s = 0; s < 12; s++) step(1'b0, 1'b0, rand_blk(), rand_blk());

        // Reset mid-feed discards the block; the next one runs normally.
        step(1'b1, 1'b0, rand_blk(), rand_blk());
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0, rand_blk(), rand_blk());
        step(1'b0, 1'b1, rand_blk(), rand_blk());
        step(1'b0, 1'b0, rand_blk(), rand_blk());
        step(1'b1, 1'b0, rand_blk(), bn);
        for (int s = 0; s < 12; s++) step(1'b0, 1'b0, rand_blk(), rand_blk());

        // Randomized traffic with occasional resets.
        for (int s = 0; s < 400; s++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
                 rand_blk(), rand_blk());
        end
        for (int s = 0; s < 14; s++) step(1'b0, 1'b0, rand_blk(), rand_blk());
        #1;
        check("res_valid_pulses", 64'(seen_rv), 64'(model_rv));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
